// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with architectural HI/LO.
// Two-cycle multiply and 32-cycle restoring divide, abortable by flush.
module mdu_iter #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t state, state_n;

    logic [2:0]    op_r;
    logic [31:0]   a_r;
    logic [31:0]   b_r;
    logic [CW-1:0] cnt;
    logic [63:0]   prod;
    logic [31:0]   rem;
    logic [31:0]   quo;
    logic [31:0]   dvs;
    logic          neg_q;
    logic          neg_r;

    logic          accept;
    logic          sgn;
    logic [63:0]   ext_a;
    logic [63:0]   ext_b;
    logic [32:0]   shifted;
    logic [32:0]   diff;
    logic [31:0]   q_fix;
    logic [31:0]   r_fix;

    assign busy    = (state != S_IDLE);
    assign accept  = (state == S_IDLE) && start && !flush;

    // Two's-complement product of extended operands is exact in 64 bits.
    assign sgn     = (op_r == OP_MULT);
    assign ext_a   = {{32{sgn & a_r[31]}}, a_r};
    assign ext_b   = {{32{sgn & b_r[31]}}, b_r};

    // One restoring step: shift in next dividend bit, trial subtract.
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, dvs};

    assign q_fix   = neg_q ? -quo : quo;
    assign r_fix   = neg_r ? -rem : rem;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    // Next-state logic; flush returns to IDLE from any busy state.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MULT || op == OP_MULTU)
                        state_n = S_MUL;
                    else if (op == OP_DIV || op == OP_DIVU)
                        state_n = S_DIV;
                end
            end
            S_MUL: begin
                if (flush || cnt == CNT_ONE) state_n = S_IDLE;
            end
            S_DIV: begin
                if (flush)                 state_n = S_IDLE;
                else if (cnt == CNT_LAST)  state_n = S_FIX;
            end
            S_FIX:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath, HI/LO writeback and registered done pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            cnt   <= '0;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            prod  <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_r  <= op;
                a_r   <= a;
                b_r   <= b;
                cnt   <= '0;
                rem   <= '0;
                quo   <= (op == OP_DIV && a[31]) ? -a : a;
                dvs   <= (op == OP_DIV && b[31]) ? -b : b;
                neg_q <= (op == OP_DIV) && (a[31] ^ b[31]);
                neg_r <= (op == OP_DIV) && a[31];
                if (op == OP_MTHI) begin
                    hi   <= a;
                    done <= 1'b1;
                end
                if (op == OP_MTLO) begin
                    lo   <= a;
                    done <= 1'b1;
                end
            end
            if (state == S_MUL && !flush) begin
                if (cnt == '0) begin
                    prod <= ext_a * ext_b;
                    cnt  <= cnt + CNT_ONE;
                end else begin
                    hi   <= prod[63:32];
                    lo   <= prod[31:0];
                    done <= 1'b1;
                end
            end
            if (state == S_DIV && !flush) begin
                rem <= diff[32] ? shifted[31:0] : diff[31:0];
                quo <= {quo[30:0], ~diff[32]};
                cnt <= cnt + CNT_ONE;
            end
            if (state == S_FIX && !flush) begin
                if (b_r == '0) begin
                    hi <= a_r;
                    lo <= 32'hFFFF_FFFF;
                end else begin
                    hi <= r_fix;
                    lo <= q_fix;
                end
                done <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the execute stage, alongside the ALU. It takes the same two 32-bit operands the ALU receives and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO against an architectural HI/LO register pair. It exposes a busy signal that the pipeline controller uses to stall on MFHI/MFLO or on a new MDU instruction. It also accepts a flush from exception handling.

## Interface
Parameters:
- DIV_CYCLES, 32: number of restoring-division iteration cycles; fixed at 32 (one quotient bit per cycle).

Ports:
- clk  input  1  clock; everything is sampled on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  request a new operation; sampled only when idle.
- op  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; codes 6 and 7 are NOP.
- a  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  input  32  rt operand (divisor / multiplier).
- flush  input  1  abort any in-flight operation and discard any same-cycle start.
- busy  output  1  high while a multi-cycle operation is in flight.
- done  output  1  one-cycle pulse; HI/LO already hold the new values in that cycle.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

## Operation
State machine: IDLE, MUL, DIV, FIX.

- **IDLE**
  - start=1 and flush=0 latches a, b and op into internal registers.
  - MULT/MULTU: go to MUL.
  - DIV/DIVU: go to DIV and clear the iteration counter.
  - MTHI/MTLO: write a into hi or lo at that same edge and stay in IDLE.
  - NOP codes: no effect.
- **MUL** (2 cycles)
  - Cycle 1 registers the 64-bit product.
  - MULT: sign-extended operands. MULTU: zero-extended operands.
  - Cycle 2 writes {hi, lo} = product[63:32], product[31:0], then goes to IDLE.
- **DIV** (32 cycles)
  - Restoring division on operand magnitudes.
  - DIV takes absolute values; DIVU uses operands as-is.
  - Uses a 33-bit partial remainder. Each cycle shifts in one dividend bit, trial-subtracts the divisor and sets one quotient bit.
  - Counter 0..31; at 31 go to FIX.
- **FIX** (1 cycle)
  - DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Writes lo = quotient, hi = remainder, then goes to IDLE.
- **Divide by zero** (either op): full latency, then hi = a, lo = 32'hFFFFFFFF.
- **0x80000000 / 0xFFFFFFFF (DIV)**: lo = 32'h80000000, hi = 0. This falls out of the magnitude path and needs no special case.
- **start while busy**: ignored; the op is not queued.
- **flush**
  - In any non-IDLE state: next state IDLE and no HI/LO write (including in FIX); done stays 0.
  - Same cycle as start in IDLE: start ignored, including MTHI/MTLO.
- **resetn=0**: state IDLE and counter 0. Regardless of flush or start, hi=0, lo=0, busy=0, done=0.

## Timing
Let start be accepted in cycle N.
- **MULT/MULTU**: busy high in N+1..N+2; HI/LO written at the end of N+2; done=1 in N+3.
- **DIV/DIVU**: busy high in N+1..N+33 (DIV iterations N+1..N+32, FIX in N+33); HI/LO written at the end of N+33; done=1 in N+34.
- **MTHI/MTLO**: busy never asserts; the register updates at the end of N; done=1 in N+1.
- busy is combinational from state (state != IDLE). done is registered.
- A new start is accepted in the same cycle that done is high.
- hi/lo are direct register outputs. The pipeline reads them while busy=0 (MFHI/MFLO stall on busy).
- Reset values: busy=0, done=0, hi=0, lo=0.

## Test plan
- **Signed multiply**: MULT a=32'hFFFFFFFD (-3), b=5 -> done in N+3, hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. Then MULTU with the same operands -> hi=32'h00000004, lo=32'hFFFFFFF1.
- **Signed divide**: DIV a=-7 (32'hFFFFFFF9), b=2 -> busy N+1..N+33, done in N+34, lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- **Edge cases**:
  - DIVU a=32'h12345678, b=0 -> hi=32'h12345678, lo=32'hFFFFFFFF.
  - DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- **Flush mid-divide**: hi/lo preloaded via MTHI 32'hAAAA0000 / MTLO 32'h5555; DIV started; flush in N+10 -> busy=0 in N+11, no done, hi/lo unchanged. Repeat with flush in N+33 (FIX) -> same result.
- **Ignored start**: start=1 with op=MULT issued at N+5 during a DIV -> ignored, and DIV results are correct at N+34. MTHI with flush=1 in the same cycle -> hi unchanged.
- **Reset mid-operation**: resetn=0 in the middle of a MULT -> next cycle hi=lo=0, busy=0, done=0. After release, start in the same cycle done is high -> accepted.
